vga_mem_arbiter: RTL and testbench
==================================

// Module: vga_mem_arbiter
// PURPOSE
//  Shares one single-port pixel memory between the VGA display fetch (reads, hard deadline)
//  and the drawing engine (reads/writes, best effort). One access is issued per clk cycle.
//  Read data returns after a fixed latency and is routed back to the requester that issued it.
//  Sits between the VGA timing/pixel path and the external/block RAM.
// PARAMETERS
//  AW        18  memory word-address width
//  DW        8   memory data width (pixels packed per word by the requesters)
//  MEM_LAT   2   memory read latency in clk cycles, range 1..7
//  MAX_WAIT  15  starvation limit for the draw port (used only with STARVE_GUARD_EN), range 1..255
// PORTS
//  clk          in   1   system clock; only clock
//  rst          in   1   asynchronous, active-low reset
//  disp_req     in   1   display read request; held until disp_gnt
//  disp_addr    in   AW  display read address
//  disp_gnt     out  1   display access issued this cycle
//  disp_rvalid  out  1   disp_rdata valid
//  disp_rdata   out  DW  display read data
//  drw_req      in   1   draw request; req/we/addr/wdata held stable until drw_gnt
//  drw_we       in   1   1 = write, 0 = read
//  drw_addr     in   AW  draw address
//  drw_wdata    in   DW  draw write data
//  drw_gnt      out  1   draw access issued this cycle
//  drw_rvalid   out  1   drw_rdata valid (reads only)
//  drw_rdata    out  DW  draw read data
//  mem_en       out  1   memory access strobe
//  mem_we       out  1   memory write enable
//  mem_addr     out  AW  memory address
//  mem_wdata    out  DW  memory write data
//  mem_rdata    in   DW  memory read data, valid MEM_LAT cycles after mem_en&&!mem_we
//  underrun     out  1   sticky: a display request was denied; cleared only by reset
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, tag pipeline cleared, wait counter 0, underrun 0.
//  - Grants are combinational from registered state + requests; mem_* are registered: access
//    granted in cycle N drives mem_* in cycle N+1. Read data for it is presented as rdata/rvalid
//    (registered) in cycle N+1+MEM_LAT+1; MEM_LAT=2 gives rvalid 4 cycles after grant.
//  - Arbitration per cycle: disp_req wins; drw_req granted only when disp_req=0. At most one
//    gnt high per cycle. With no grant, mem_en=0 next cycle.
//  - Tag pipeline: MEM_LAT+1 stages of {valid, owner}; each read pushes {1, owner}; its output
//    steers mem_rdata to disp_* or drw_*. Writes push {0, x}; drw_rvalid is never raised for a write.
//  - Only the selected port's rvalid is high; the other rdata holds its last value.
//  - Simultaneous disp_req and drw_req: display granted, draw stalls, and its inputs must stay held.
//  - Reset mid-operation: in-flight reads are discarded; no rvalid after rst deassert.
// CONFIGURATION
//  STARVE_GUARD_EN defined: 8-bit wait counter increments each cycle drw_req=1 && !drw_gnt,
//    clears on drw_gnt or drw_req=0. When counter == MAX_WAIT, the next cycle grants draw even if
//    disp_req=1; that display denial sets underrun. Display then wins again.
//  Not defined: strict display priority; counter absent; underrun is still present and
//    stays 0 (display is never denied).
// STRUCTURE
//  - Shared package vga_pkg: owner encoding (OWN_DISP=0, OWN_DRAW=1), default AW/DW, and a tag
//    struct {valid, owner}.
//  - One sub-module: vga_rd_tag_pipe (MEM_LAT+1 deep shift register of tags with async reset).
//  - Arbiter, wait counter and mem_* registers in the top-level module.
// TESTING
//  1 Reset: drive both requests during rst=0 -> all outputs 0; after release, first grant next cycle.
//  2 Display only: disp_req with addr 0..7 back-to-back -> disp_gnt every cycle; mem_addr 0..7
//    one cycle later; disp_rvalid 4 cycles after each grant (MEM_LAT=2), data in order.
//  3 Draw write then read: write 0x5A to 0x100, then read 0x100 with display idle ->
//    one mem_we pulse; drw_rvalid exactly once with 0x5A; no disp_rvalid.
//  4 Contention without the guard: disp_req held 40 cycles and drw_req held -> drw_gnt stays 0
//    until disp_req drops, then drw_gnt the next cycle; underrun stays 0.
//  5 STARVE_GUARD_EN, MAX_WAIT=15: same stimulus -> drw_gnt on the 16th waiting cycle, disp_gnt 0
//    that cycle, underrun=1 and sticky; display granted the following cycle.
//  6 Reset with 3 reads in flight -> no rvalid after release; tags empty; underrun cleared.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared owner encoding, default widths and read-tag type for the VGA memory arbiter
package vga_pkg;

  localparam int VGA_AW = 18;
  localparam int VGA_DW = 8;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_DRAW = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/vga_rd_tag_pipe.sv
// rtl/vga_rd_tag_pipe.sv - fixed-depth shift register of read tags that tracks in-flight memory reads
import vga_pkg::*;

module vga_rd_tag_pipe #(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t push_tag,
  output rd_tag_t pop_tag
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign pop_tag = stage[DEPTH-1];

endmodule

// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - display/draw arbiter for a single-port pixel memory with tagged read return
// Optional draw starvation guard enabled by defining STARVE_GUARD_EN.
import vga_pkg::*;

module vga_mem_arbiter #(
  parameter int AW       = VGA_AW,
  parameter int DW       = VGA_DW,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          drw_req,
  input  logic          drw_we,
  input  logic [AW-1:0] drw_addr,
  input  logic [DW-1:0] drw_wdata,
  output logic          drw_gnt,
  output logic          drw_rvalid,
  output logic [DW-1:0] drw_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          underrun
);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
    $error("vga_mem_arbiter: MEM_LAT out of range 1..7");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_wait
    $error("vga_mem_arbiter: MAX_WAIT out of range 1..255");
  end

  logic    starve;
  rd_tag_t push_tag;
  rd_tag_t pop_tag;

`ifdef STARVE_GUARD_EN
  logic [7:0] wait_cnt;

  // Once draw has waited MAX_WAIT cycles it takes the very next slot, even over display.
  assign starve = drw_req && (wait_cnt == 8'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!drw_req || drw_gnt) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Grants are masked while reset is asserted so nothing is issued from stale requests.
  assign disp_gnt = rst && disp_req && !starve;
  assign drw_gnt  = rst && drw_req && (!disp_req || starve);

  always_comb begin
    push_tag       = '0;
    push_tag.valid = disp_gnt || (drw_gnt && !drw_we);
    push_tag.owner = disp_gnt ? OWN_DISP : OWN_DRAW;
  end

  vga_rd_tag_pipe #(
    .DEPTH(MEM_LAT + 1)
  ) u_tags (
    .clk     (clk),
    .rst     (rst),
    .push_tag(push_tag),
    .pop_tag (pop_tag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      underrun  <= 1'b0;
    end else begin
      mem_en <= disp_gnt || drw_gnt;
      mem_we <= drw_gnt && drw_we;
      if (disp_gnt) begin
        mem_addr <= disp_addr;
      end else if (drw_gnt) begin
        mem_addr <= drw_addr;
      end
      if (drw_gnt && drw_we) mem_wdata <= drw_wdata;
      if (disp_req && !disp_gnt) underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      drw_rvalid  <= 1'b0;
      drw_rdata   <= '0;
    end else begin
      disp_rvalid <= pop_tag.valid && (pop_tag.owner == OWN_DISP);
      drw_rvalid  <= pop_tag.valid && (pop_tag.owner == OWN_DRAW);
      if (pop_tag.valid && (pop_tag.owner == OWN_DISP)) disp_rdata <= mem_rdata;
      if (pop_tag.valid && (pop_tag.owner == OWN_DRAW)) drw_rdata  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb/tb_vga_mem_arbiter.sv - directed self-checking bench for vga_mem_arbiter (MEM_LAT=2, MAX_WAIT=15)
module tb_vga_mem_arbiter;

  localparam int AW = 18;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          drw_req = 1'b0;
  logic          drw_we = 1'b0;
  logic [AW-1:0] drw_addr = '0;
  logic [DW-1:0] drw_wdata = '0;
  logic          drw_gnt;
  logic          drw_rvalid;
  logic [DW-1:0] drw_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          underrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  vga_mem_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(2), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .drw_req(drw_req), .drw_we(drw_we), .drw_addr(drw_addr), .drw_wdata(drw_wdata),
    .drw_gnt(drw_gnt), .drw_rvalid(drw_rvalid), .drw_rdata(drw_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .underrun(underrun)
  );

  // Memory model: contents start as addr ^ 0x3C, read data appears two cycles after mem_en.
  logic [DW-1:0] memv [1024];
  logic [DW-1:0] rs0 = '0;
  logic [DW-1:0] rs1 = '0;
  logic          init_done = 1'b0;
  assign mem_rdata = rs1;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) memv[i] <= 8'(i) ^ 8'h3C;
      init_done <= 1'b1;
    end else if (mem_en && mem_we) begin
      memv[mem_addr[9:0]] <= mem_wdata;
    end
    rs0 <= (mem_en && !mem_we) ? memv[mem_addr[9:0]] : 8'h00;
    rs1 <= rs0;
    cyc <= cyc + 1;
  end

  int            gq[$];
  int            vq[$];
  logic [DW-1:0] dq[$];
  int            drw_rv_cnt = 0;
  logic [DW-1:0] drw_last = '0;
  int            we_cnt = 0;

  always @(negedge clk) begin
    if (disp_gnt) gq.push_back(cyc);
    if (disp_rvalid) begin
      vq.push_back(cyc);
      dq.push_back(disp_rdata);
    end
    if (drw_rvalid) begin
      drw_rv_cnt++;
      drw_last = drw_rdata;
    end
    if (mem_en && mem_we) we_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int            gb, vb, db, wb, first_drw, disp_cnt;
  logic          d16, d17, u17;

  initial begin
    // Reset with both requests asserted
    disp_req = 1'b1;
    drw_req  = 1'b1;
    tick(3);
    #3;
    chk("rst_disp_gnt", 32'(disp_gnt), 32'd0);
    chk("rst_drw_gnt", 32'(drw_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
    chk("rst_drw_rvalid", 32'(drw_rvalid), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    tick(1);
    rst = 1'b1;
    #3;
    chk("rel_disp_gnt", 32'(disp_gnt), 32'd1);
    chk("rel_drw_gnt", 32'(drw_gnt), 32'd0);
    tick(1);
    disp_req = 1'b0;
    drw_req  = 1'b0;
    tick(8);

    // Display-only burst, addresses 0..7
    gb = gq.size();
    vb = vq.size();
    for (int i = 0; i < 8; i++) begin
      disp_req  = 1'b1;
      disp_addr = 18'(i);
      #3;
      chk("burst_disp_gnt", 32'(disp_gnt), 32'd1);
      tick(1);
      disp_req = 1'b0;
      chk("burst_mem_addr", 32'(mem_addr), 32'(i));
      chk("burst_mem_en", 32'(mem_en), 32'd1);
    end
    tick(8);
    chk("burst_rv_count", 32'(vq.size() - vb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (vb + i < vq.size() && gb + i < gq.size()) begin
        chk("burst_latency", 32'(vq[vb+i] - gq[gb+i]), 32'd4);
        chk("burst_data", 32'(dq[vb+i]), 32'(8'(i) ^ 8'h3C));
      end
    end

    // Draw write 0x5A to 0x100, then read it back
    db = drw_rv_cnt;
    wb = we_cnt;
    vb = vq.size();
    drw_req   = 1'b1;
    drw_we    = 1'b1;
    drw_addr  = 18'h100;
    drw_wdata = 8'h5A;
    #3;
    chk("wr_drw_gnt", 32'(drw_gnt), 32'd1);
    tick(1);
    drw_we = 1'b0;
    #3;
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h100);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h5A);
    chk("rd_drw_gnt", 32'(drw_gnt), 32'd1);
    tick(1);
    drw_req = 1'b0;
    tick(8);
    chk("wr_we_pulses", 32'(we_cnt - wb), 32'd1);
    chk("rd_drw_rv_count", 32'(drw_rv_cnt - db), 32'd1);
    chk("rd_drw_data", 32'(drw_last), 32'h5A);
    chk("rd_no_disp_rv", 32'(vq.size() - vb), 32'd0);

    // Contention: display held 40 cycles, draw read waiting
    disp_req  = 1'b1;
    disp_addr = 18'h20;
    drw_we    = 1'b0;
    drw_addr  = 18'h30;
    first_drw = 0;
    disp_cnt  = 0;
    d16 = 1'b0;
    d17 = 1'b0;
    u17 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      drw_req = (first_drw == 0);
      #3;
      if (drw_gnt && first_drw == 0) first_drw = k;
      if (disp_gnt) disp_cnt++;
      if (k == 16) d16 = disp_gnt;
      if (k == 17) begin
        d17 = disp_gnt;
        u17 = underrun;
      end
      tick(1);
    end
`ifdef STARVE_GUARD_EN
    chk("guard_first_drw", 32'(first_drw), 32'd16);
    chk("guard_disp_gnt16", 32'(d16), 32'd0);
    chk("guard_disp_gnt17", 32'(d17), 32'd1);
    chk("guard_underrun17", 32'(u17), 32'd1);
    chk("guard_disp_cnt", 32'(disp_cnt), 32'd39);
    chk("guard_underrun_sticky", 32'(underrun), 32'd1);
    disp_req = 1'b0;
    drw_req  = 1'b0;
`else
    chk("strict_first_drw", 32'(first_drw), 32'd0);
    chk("strict_disp_cnt", 32'(disp_cnt), 32'd40);
    chk("strict_disp_gnt17", 32'(d17), 32'd1);
    chk("strict_underrun", 32'(underrun), 32'd0);
    disp_req = 1'b0;
    drw_req  = 1'b1;
    #3;
    chk("strict_drw_gnt_after", 32'(drw_gnt), 32'd1);
    chk("strict_disp_gnt_after", 32'(disp_gnt), 32'd0);
    tick(1);
    drw_req = 1'b0;
    chk("strict_underrun_end", 32'(underrun), 32'd0);
`endif
    tick(10);

    // Reset with three display reads in flight
    for (int i = 0; i < 3; i++) begin
      disp_req  = 1'b1;
      disp_addr = 18'(8'h40 + i);
      tick(1);
    end
    disp_req = 1'b0;
    rst = 1'b0;
    vb = vq.size();
    db = drw_rv_cnt;
    tick(2);
    #3;
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    tick(1);
    rst = 1'b1;
    tick(8);
    chk("mid_rst_disp_rv", 32'(vq.size() - vb), 32'd0);
    chk("mid_rst_drw_rv", 32'(drw_rv_cnt - db), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    chk("mid_rst_idle_mem_en", 32'(mem_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
